eth_rxethframer: RTL and testbench

Receive-side MII framer: the counterpart of the transmit MAC. It takes nibbles from the PHY (MRxD/MRxDV), strips the preamble and SFD, and assembles bytes LSB-nibble first. It streams the bytes upward with start/end markers, checks the CRC-32 FCS, and checks frame length against the same MinFL/MaxFL/HugEn register values the transmit path uses.

---
 rtl/eth_rxethframer.sv | 139 +++++++++++++
 tb/tb_eth_rxethframer.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/eth_rxethframer.sv
// eth_rxethframer: MII receive framer; strips preamble/SFD, assembles bytes, checks FCS and frame length
module eth_rxethframer (
  input  logic        MRxClk,
  input  logic        Reset,
  input  logic        MRxDV,
  input  logic [3:0]  MRxD,
  input  logic        HugEn,
  input  logic [15:0] MinFL,
  input  logic [15:0] MaxFL,
  output logic [7:0]  RxData,
  output logic        RxValid,
  output logic        RxStartFrm,
  output logic        RxEndFrm,
  output logic [15:0] RxByteCnt,
  output logic        CrcError,
  output logic        ShortFrame,
  output logic        LongFrame,
  output logic        DribbleNibble
);
  typedef enum logic [2:0] {IDLE, PREAM, DATA0, DATA1, DROP} state_t;
  state_t state_q, state_d;
  logic [3:0]  low_q, low_d;
  logic [31:0] crc_q, crc_d;
  logic [7:0]  data_q, data_d;
  logic [15:0] cnt_q, cnt_d, cnt_inc;
  logic valid_q, valid_d, start_q, start_d, end_q, end_d;
  logic over_q, over_d, over_now, fin;
  logic crc_err_q, crc_err_d, short_q, short_d, long_q, long_d, drib_q, drib_d;
  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c;
    for (int i = 0; i < 8; i++) r = (r[0] ^ d[i]) ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    return r;
  endfunction
  always_comb begin
    state_d = state_q;
    low_d = low_q;
    crc_d = crc_q;
    data_d = data_q;
    valid_d = 1'b0;
    start_d = 1'b0;
    end_d = 1'b0;
    cnt_d = cnt_q;
    over_d = over_q;
    crc_err_d = crc_err_q;
    short_d = short_q;
    long_d = long_q;
    drib_d = drib_q;
    fin = 1'b0;
    cnt_inc = (&cnt_q) ? cnt_q : cnt_q + 16'd1;
    // once a byte overruns MaxFL, delivery stays off for the rest of the frame
    over_now = over_q | (!HugEn && cnt_inc > MaxFL);
    case (state_q)
      IDLE: if (MRxDV) state_d = (MRxD == 4'h5) ? PREAM : DROP;
      PREAM:
        if (!MRxDV) state_d = IDLE;
        else if (MRxD == 4'hD) begin
          state_d = DATA0;
          crc_d = '1;
          cnt_d = '0;
          over_d = 1'b0;
          crc_err_d = 1'b0;
          short_d = 1'b0;
          long_d = 1'b0;
          drib_d = 1'b0;
        end else if (MRxD != 4'h5) state_d = DROP;
      DROP: if (!MRxDV) state_d = IDLE;
      DATA0:
        if (MRxDV) begin
          low_d = MRxD;
          state_d = DATA1;
        end else begin
          state_d = IDLE;
          fin = 1'b1;
        end
      DATA1:
        if (MRxDV) begin
          state_d = DATA0;
          data_d = {MRxD, low_q};
          valid_d = !over_now;
          start_d = !over_now && cnt_q == 16'd0;
          cnt_d = cnt_inc;
          crc_d = crc_byte(crc_q, {MRxD, low_q});
          over_d = over_now;
        end else begin
          state_d = IDLE;
          fin = 1'b1;
        end
      default: state_d = IDLE;
    endcase
    if (fin && cnt_q != 16'd0) begin
      end_d = 1'b1;
      crc_err_d = crc_q != 32'hDEBB20E3;
      short_d = cnt_q < MinFL;
      long_d = over_q;
      drib_d = state_q == DATA1;
    end
  end
  always_ff @(posedge MRxClk) begin
    if (Reset) begin
      state_q <= IDLE;
      low_q <= '0;
      crc_q <= '1;
      data_q <= '0;
      cnt_q <= '0;
      valid_q <= 1'b0;
      start_q <= 1'b0;
      end_q <= 1'b0;
      over_q <= 1'b0;
      crc_err_q <= 1'b0;
      short_q <= 1'b0;
      long_q <= 1'b0;
      drib_q <= 1'b0;
    end else begin
      state_q <= state_d;
      low_q <= low_d;
      crc_q <= crc_d;
      data_q <= data_d;
      cnt_q <= cnt_d;
      valid_q <= valid_d;
      start_q <= start_d;
      end_q <= end_d;
      over_q <= over_d;
      crc_err_q <= crc_err_d;
      short_q <= short_d;
      long_q <= long_d;
      drib_q <= drib_d;
    end
  end
  assign RxData = data_q;
  assign RxValid = valid_q;
  assign RxStartFrm = start_q;
  assign RxEndFrm = end_q;
  assign RxByteCnt = cnt_q;
  assign CrcError = crc_err_q;
  assign ShortFrame = short_q;
  assign LongFrame = long_q;
  assign DribbleNibble = drib_q;
endmodule

// File: tb/tb_eth_rxethframer.sv
// tb_eth_rxethframer: scoreboard bench for the MII receive framer
module tb_eth_rxethframer;
  logic MRxClk = 1'b0, Reset = 1'b1, MRxDV = 1'b0, HugEn = 1'b0;
  logic [3:0] MRxD = '0;
  logic [15:0] MinFL = 16'd64, MaxFL = 16'd1518;
  logic [7:0] RxData;
  logic RxValid, RxStartFrm, RxEndFrm, CrcError, ShortFrame, LongFrame, DribbleNibble;
  logic [15:0] RxByteCnt;
  eth_rxethframer dut (
    .MRxClk(MRxClk), .Reset(Reset), .MRxDV(MRxDV), .MRxD(MRxD), .HugEn(HugEn),
    .MinFL(MinFL), .MaxFL(MaxFL), .RxData(RxData), .RxValid(RxValid),
    .RxStartFrm(RxStartFrm), .RxEndFrm(RxEndFrm), .RxByteCnt(RxByteCnt),
    .CrcError(CrcError), .ShortFrame(ShortFrame), .LongFrame(LongFrame),
    .DribbleNibble(DribbleNibble)
  );
  always #5 MRxClk = ~MRxClk;
  typedef struct {logic [7:0] data; logic start;} bexp_t;
  typedef struct {logic [15:0] cnt; logic crc, sh, lg, dr; int nv, gap;} eexp_t;
  bexp_t exp_q[$];
  eexp_t end_q[$];
  logic [7:0] frm[$];
  int n_chk = 0, n_pass = 0, cyc = 0, nval = 0, last_v = 0;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask
  function automatic logic [31:0] crc32(input logic [7:0] b[$]);
    logic [31:0] c = '1;
    foreach (b[k]) for (int i = 0; i < 8; i++) c = (c[0] ^ b[k][i]) ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    return ~c;
  endfunction
  always @(posedge MRxClk) cyc++;
  always @(negedge MRxClk) begin
    bexp_t b;
    eexp_t e;
    if (Reset) nval = 0;
    else begin
      if (RxValid) begin
        if (exp_q.size() == 0) chk("unexpected_valid", 1, 0);
        else begin
          b = exp_q.pop_front();
          chk("data", RxData, b.data);
          chk("start", RxStartFrm, b.start);
        end
        nval++;
        last_v = cyc;
      end else if (RxStartFrm) chk("start_without_valid", 1, 0);
      if (RxEndFrm) begin
        if (end_q.size() == 0) chk("unexpected_end", 1, 0);
        else begin
          e = end_q.pop_front();
          chk("bytecnt", RxByteCnt, e.cnt);
          chk("crcerr", CrcError, e.crc);
          chk("short", ShortFrame, e.sh);
          chk("long", LongFrame, e.lg);
          chk("dribble", DribbleNibble, e.dr);
          chk("nvalid", nval, e.nv);
          if (e.gap != 0) chk("end_gap", cyc - last_v, e.gap);
        end
        nval = 0;
      end
    end
  end
  task automatic nib(input logic dv, input logic [3:0] d);
    @(posedge MRxClk);
    #1;
    MRxDV = dv;
    MRxD = d;
  endtask
  task automatic preamble();
    for (int i = 0; i < 15; i++) nib(1'b1, 4'h5);
    nib(1'b1, 4'hD);
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) nib(1'b0, 4'h0);
  endtask
  // appends FCS to frm, optionally corrupts one byte afterwards, and sends it
  task automatic send_frame(input int bad_idx, input bit drib);
    logic [31:0] fcs;
    eexp_t e;
    int n, lim;
    fcs = crc32(frm);
    for (int i = 0; i < 4; i++) frm.push_back(fcs[8*i +: 8]);
    if (bad_idx >= 0) frm[bad_idx] = 8'hFF;
    n = frm.size();
    lim = (!HugEn && n > int'(MaxFL)) ? int'(MaxFL) : n;
    for (int i = 0; i < lim; i++) exp_q.push_back('{frm[i], i == 0});
    e.cnt = 16'(n);
    e.crc = bad_idx >= 0;
    e.sh = n < int'(MinFL);
    e.lg = lim != n;
    e.dr = drib;
    e.nv = lim;
    e.gap = (lim != n) ? 0 : (drib ? 2 : 1);
    end_q.push_back(e);
    preamble();
    foreach (frm[k]) begin
      nib(1'b1, frm[k][3:0]);
      nib(1'b1, frm[k][7:4]);
    end
    if (drib) nib(1'b1, 4'hA);
    idle(4);
  endtask
  task automatic build(input int n);
    frm.delete();
    for (int i = 0; i < n; i++) frm.push_back(8'(i));
  endtask
  initial begin
    idle(3);
    @(negedge MRxClk);
    chk("rst_data", RxData, 0);
    chk("rst_valid", RxValid, 0);
    chk("rst_cnt", RxByteCnt, 0);
    chk("rst_status", {RxStartFrm, RxEndFrm, CrcError, ShortFrame, LongFrame, DribbleNibble}, 0);
    Reset = 1'b0;
    idle(2);
    build(60); send_frame(-1, 1'b0);
    build(60); send_frame(10, 1'b0);
    build(16); send_frame(-1, 1'b0);
    build(16); send_frame(-1, 1'b1);
    preamble(); nib(1'b1, 4'h7); idle(3);
    MaxFL = 16'h0600;
    build(1536); send_frame(-1, 1'b0);
    HugEn = 1'b1;
    build(1536); send_frame(-1, 1'b0);
    HugEn = 1'b0;
    nib(1'b1, 4'h3); preamble();
    for (int i = 0; i < 20; i++) nib(1'b1, 4'(i));
    idle(3);
    build(60); send_frame(-1, 1'b0);
    build(60);
    preamble();
    for (int i = 0; i < 30; i++) begin
      exp_q.push_back('{frm[i], i == 0});
      nib(1'b1, frm[i][3:0]);
      nib(1'b1, frm[i][7:4]);
    end
    nib(1'b1, frm[30][3:0]);
    @(posedge MRxClk);
    #1;
    Reset = 1'b1;
    MRxD = frm[30][7:4];
    @(posedge MRxClk);
    #1;
    Reset = 1'b0;
    MRxD = frm[31][3:0];
    @(negedge MRxClk);
    chk("midrst_valid", RxValid, 0);
    chk("midrst_end", RxEndFrm, 0);
    chk("midrst_cnt", RxByteCnt, 0);
    chk("midrst_data", RxData, 0);
    nib(1'b1, frm[31][7:4]);
    for (int i = 32; i < 60; i++) begin
      nib(1'b1, frm[i][3:0]);
      nib(1'b1, frm[i][7:4]);
    end
    idle(4);
    build(60); send_frame(-1, 1'b0);
    idle(4);
    chk("bytes_left", exp_q.size(), 0);
    chk("ends_left", end_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
